// File: rtl/masked_xor_pg_pipe_if.sv
// Handshake bundle for the masked XOR pipe:
// operand shares + randomness in, result shares out.
interface masked_xor_pg_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_0;
  logic [WIDTH-1:0] a_1;
  logic [WIDTH-1:0] b_0;
  logic [WIDTH-1:0] b_1;
  logic [WIDTH-1:0] r0;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y_0;
  logic [WIDTH-1:0] y_1;

  modport slave (
    input  in_valid, a_0, a_1, b_0, b_1,
    input  r0, r1, r2, out_ready,
    output in_ready, out_valid, y_0, y_1
  );

  modport master (
    output in_valid, a_0, a_1, b_0, b_1,
    output r0, r1, r2, out_ready,
    input  in_ready, out_valid, y_0, y_1
  );
endinterface

// File: rtl/masked_xor_pg_pipe.sv
// Two-share masked XOR built as (a&~b)|(~a&b)
// from registered DOM AND gadgets, 3-stage pipe.
module masked_xor_pg_pipe #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  masked_xor_pg_pipe_if.slave bus
);
  typedef logic [WIDTH-1:0] w_t;

  typedef struct packed {
    w_t p00;
    w_t p11;
    w_t p01;
    w_t p10;
    w_t q00;
    w_t q11;
    w_t q01;
    w_t q10;
    w_t r2;
  } s1_t;

  typedef struct packed {
    w_t g1_0;
    w_t g1_1;
    w_t g2_0;
    w_t g2_1;
    w_t r2;
  } s2_t;

  typedef struct packed {
    w_t g1_0;
    w_t g1_1;
    w_t g2_0;
    w_t g2_1;
    w_t c00;
    w_t c11;
    w_t c01;
    w_t c10;
  } s3_t;

  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic v3_q, v3_d;
  s1_t  s1_q, s1_d, s1_c;
  s2_t  s2_q, s2_d, s2_c;
  s3_t  s3_q, s3_d, s3_c;

  logic en;
  logic acc;
  w_t   na0, na1, nb0, nb1;

  // Masked NOT flips share 0 only.
  assign na0 = ~bus.a_0;
  assign na1 = bus.a_1;
  assign nb0 = ~bus.b_0;
  assign nb1 = bus.b_1;

  assign en           = ~v3_q | bus.out_ready;
  assign bus.in_ready = en & ~flush;
  assign acc          = bus.in_valid & bus.in_ready;

  always_comb begin
    s1_c     = '0;
    s1_c.p00 = bus.a_0 & nb0;
    s1_c.p11 = bus.a_1 & nb1;
    s1_c.p01 = (bus.a_0 & nb1) ^ bus.r0;
    s1_c.p10 = (bus.a_1 & nb0) ^ bus.r0;
    s1_c.q00 = na0 & bus.b_0;
    s1_c.q11 = na1 & bus.b_1;
    s1_c.q01 = (na0 & bus.b_1) ^ bus.r1;
    s1_c.q10 = (na1 & bus.b_0) ^ bus.r1;
    s1_c.r2  = bus.r2;
  end

  always_comb begin
    s2_c      = '0;
    s2_c.g1_0 = s1_q.p00 ^ s1_q.p01;
    s2_c.g1_1 = s1_q.p11 ^ s1_q.p10;
    s2_c.g2_0 = s1_q.q00 ^ s1_q.q01;
    s2_c.g2_1 = s1_q.q11 ^ s1_q.q10;
    s2_c.r2   = s1_q.r2;
  end

  always_comb begin
    s3_c      = '0;
    s3_c.g1_0 = s2_q.g1_0;
    s3_c.g1_1 = s2_q.g1_1;
    s3_c.g2_0 = s2_q.g2_0;
    s3_c.g2_1 = s2_q.g2_1;
    s3_c.c00  = s2_q.g1_0 & s2_q.g2_0;
    s3_c.c11  = s2_q.g1_1 & s2_q.g2_1;
    s3_c.c01  = (s2_q.g1_0 & s2_q.g2_1) ^ s2_q.r2;
    s3_c.c10  = (s2_q.g1_1 & s2_q.g2_0) ^ s2_q.r2;
  end

  // Empty slots carry zeros so no stale shares linger.
  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
      s1_d = '0;
      s2_d = '0;
      s3_d = '0;
    end else if (en) begin
      v1_d = acc;
      v2_d = v1_q;
      v3_d = v2_q;
      s1_d = acc  ? s1_c : '0;
      s2_d = v1_q ? s2_c : '0;
      s3_d = v2_q ? s3_c : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.y_0 = s3_q.g1_0 ^ s3_q.g2_0
                 ^ s3_q.c00 ^ s3_q.c01;
  assign bus.y_1 = s3_q.g1_1 ^ s3_q.g2_1
                 ^ s3_q.c11 ^ s3_q.c10;
endmodule

// File: tb/tb_masked_xor_pg_pipe.sv
// Directed bench for masked_xor_pg_pipe:
// latency, masking, stalls, bubbles, flush, async reset.
module tb_masked_xor_pg_pipe;
  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   errors;

  masked_xor_pg_pipe_if #(.WIDTH(8)) bus ();

  masked_xor_pg_pipe #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a0,
                       input logic [7:0] a1,
                       input logic [7:0] b0,
                       input logic [7:0] b1,
                       input logic [7:0] r0,
                       input logic [7:0] r1,
                       input logic [7:0] r2);
    bus.in_valid = 1'b1;
    bus.a_0 = a0;
    bus.a_1 = a1;
    bus.b_0 = b0;
    bus.b_1 = b1;
    bus.r0  = r0;
    bus.r1  = r1;
    bus.r2  = r2;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.a_0 = '0;
    bus.a_1 = '0;
    bus.b_0 = '0;
    bus.b_1 = '0;
    bus.r0  = '0;
    bus.r1  = '0;
    bus.r2  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] qa, qb, qma, qmb;
  logic [7:0] exp_q[$];
  logic [7:0] bp_a[4];
  logic [7:0] bp_b[4];
  logic [7:0] held0, held1;
  int         sent, got, stall;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    flush  = 1'b0;
    bus.out_ready = 1'b1;
    idle();

    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_y0", 32'(bus.y_0), 32'h0);
    chk("rst_y1", 32'(bus.y_1), 32'h0);
    #5 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(bus.in_ready), 32'h0);
    flush = 1'b0;
    tick();

    // unmasked sanity: 5A ^ 3C = 66
    drive(8'h5A, 8'h00, 8'h3C, 8'h00, 0, 0, 0);
    #1;
    chk("t1_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    idle();
    chk("t1_lat1", 32'(bus.out_valid), 32'h0);
    tick();
    chk("t1_lat2", 32'(bus.out_valid), 32'h0);
    tick();
    chk("t1_valid", 32'(bus.out_valid), 32'h1);
    chk("t1_y0", 32'(bus.y_0), 32'h66);
    chk("t1_y1", 32'(bus.y_1), 32'h00);
    tick();
    chk("t1_drain", 32'(bus.out_valid), 32'h0);

    // masked: a=F0 b=33 with r=01,02,04
    drive(8'hFF, 8'h0F, 8'h00, 8'h33,
          8'h01, 8'h02, 8'h04);
    tick();
    idle();
    tick();
    tick();
    chk("t2_valid", 32'(bus.out_valid), 32'h1);
    chk("t2_y0", 32'(bus.y_0), 32'hCA);
    chk("t2_y1", 32'(bus.y_1), 32'h09);
    tick();

    // back-to-back random stream
    for (int c = 0; c < 42; c++) begin
      if (c < 40) begin
        qa  = 8'($urandom);
        qb  = 8'($urandom);
        qma = 8'($urandom);
        qmb = 8'($urandom);
        drive(qa ^ qma, qma, qb ^ qmb, qmb,
              8'($urandom), 8'($urandom),
              8'($urandom));
        exp_q.push_back(qa ^ qb);
      end else begin
        idle();
      end
      tick();
      if (c >= 2) begin
        chk("stream_valid",
            32'(bus.out_valid), 32'h1);
        chk("stream_y",
            32'(bus.y_0 ^ bus.y_1),
            32'(exp_q.pop_front()));
      end
    end
    idle();
    tick();
    chk("stream_drain", 32'(bus.out_valid), 32'h0);

    // backpressure: 4 bundles, 5 stalled cycles
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = 8'(1 << i);
      bp_b[i] = 8'(8'h10 << i);
    end
    sent  = 0;
    got   = 0;
    stall = 0;
    held0 = '0;
    held1 = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (sent < 4)
        drive(bp_a[sent] ^ 8'hA5, 8'hA5,
              bp_b[sent] ^ 8'h5A, 8'h5A,
              8'h3C + 8'(sent), 8'hC3,
              8'h96 ^ 8'(sent));
      else
        idle();
      bus.out_ready = !(bus.out_valid && stall < 5);
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        if (stall > 0) begin
          chk("bp_hold_y0", 32'(bus.y_0), 32'(held0));
          chk("bp_hold_y1", 32'(bus.y_1), 32'(held1));
          chk("bp_in_ready",
              32'(bus.in_ready), 32'h0);
        end
        held0 = bus.y_0;
        held1 = bus.y_1;
        stall++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (got < 4)
          chk("bp_y", 32'(bus.y_0 ^ bus.y_1),
              32'(bp_a[got] ^ bp_b[got]));
        got++;
      end
      if (bus.in_valid && bus.in_ready)
        sent++;
      tick();
    end
    chk("bp_count", got, 4);
    chk("bp_stalls", stall, 5);
    idle();
    bus.out_ready = 1'b1;
    #1;
    chk("bp_no_dup", 32'(bus.out_valid), 32'h0);
    tick();

    // bubble: accept, idle, accept
    drive(8'h01, 8'h00, 8'h02, 8'h00, 0, 0, 0);
    tick();
    idle();
    tick();
    chk("bub_s1_zero", 32'(dut.s1_q == '0), 32'h1);
    drive(8'hF0, 8'h00, 8'h0F, 8'h00, 0, 0, 0);
    tick();
    idle();
    chk("bub_v_a", 32'(bus.out_valid), 32'h1);
    chk("bub_y_a", 32'(bus.y_0), 32'h03);
    tick();
    chk("bub_gap", 32'(bus.out_valid), 32'h0);
    tick();
    chk("bub_v_b", 32'(bus.out_valid), 32'h1);
    chk("bub_y_b", 32'(bus.y_0), 32'hFF);
    tick();

    // flush with 3 in flight
    for (int i = 0; i < 3; i++) begin
      drive(8'h11 << i, 8'h0, 8'h81, 8'h0, 0, 0, 0);
      tick();
    end
    drive(8'h77, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    flush = 1'b0;
    idle();
    chk("fl_valid", 32'(bus.out_valid), 32'h0);
    chk("fl_y0", 32'(bus.y_0), 32'h0);
    chk("fl_y1", 32'(bus.y_1), 32'h0);
    chk("fl_s1", 32'(dut.s1_q == '0), 32'h1);
    chk("fl_s2", 32'(dut.s2_q == '0), 32'h1);
    chk("fl_s3", 32'(dut.s3_q == '0), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_empty", 32'(bus.out_valid), 32'h0);
    end

    // async reset while full and stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(8'h0F, 8'h00, 8'hF0, 8'h00, 0, 0, 0);
      tick();
    end
    idle();
    chk("ar_full", 32'(bus.out_valid), 32'h1);
    chk("ar_full_y", 32'(bus.y_0), 32'hFF);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.out_valid), 32'h0);
    chk("ar_y0", 32'(bus.y_0), 32'h0);
    chk("ar_y1", 32'(bus.y_1), 32'h0);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("ar_idle", 32'(bus.out_valid), 32'h0);
    drive(8'hFF, 8'h0F, 8'h00, 8'h33,
          8'h01, 8'h02, 8'h04);
    tick();
    idle();
    tick();
    tick();
    chk("ar_valid2", 32'(bus.out_valid), 32'h1);
    chk("ar_y0b", 32'(bus.y_0), 32'hCA);
    chk("ar_y1b", 32'(bus.y_1), 32'h09);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
